// File: rtl/clk_ce_gen.sv
// rtl/clk_ce_gen.sv - multi-channel fractional clock-enable generator gated on debounced PLL lock
module clk_ce_gen #(
    parameter int  CHANNELS    = 2,
    parameter int  ACC_W       = 16,
    parameter int  LOCK_CYCLES = 1024,
    parameter int  DEF_NUM     = 1,
    parameter int  DEF_DEN     = 2,
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                pll_locked,
    input  logic                cfg_wr,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [ACC_W-1:0]    cfg_num,
    input  logic [ACC_W-1:0]    cfg_den,
    output logic                cfg_ready,
    output logic                cfg_err,
    input  logic                sync_req,
    output logic [CHANNELS-1:0] ce,
    output logic                locked
);

    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {ST_UNLOCKED, ST_SETTLE, ST_RUN} state_t;

    state_t              state;
    state_t              state_nxt;
    logic                lock_meta;
    logic                lock_sync;
    logic [CNT_W-1:0]    settle_cnt;

    logic [ACC_W-1:0]    acc [CHANNELS];
    logic [ACC_W-1:0]    num [CHANNELS];
    logic [ACC_W-1:0]    den [CHANNELS];
    logic [ACC_W:0]      sum [CHANNELS];
    logic [CHANNELS-1:0] wrap;

    logic                pend_valid;
    logic [CH_W-1:0]     pend_ch;
    logic [ACC_W-1:0]    pend_num;
    logic [ACC_W-1:0]    pend_den;

    logic                in_run;
    logic                run_stay;
    logic                cfg_legal;
    logic                cfg_take;
    logic                commit;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_UNLOCKED: if (lock_sync) state_nxt = ST_SETTLE;
            ST_SETTLE: begin
                if (!lock_sync)                 state_nxt = ST_UNLOCKED;
                else if (settle_cnt == CNT_LAST) state_nxt = ST_RUN;
            end
            ST_RUN:      if (!lock_sync) state_nxt = ST_UNLOCKED;
            default:     state_nxt = ST_UNLOCKED;
        endcase
    end

    // One extra bit on the sum keeps acc+num >= den exact even near 2^ACC_W
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            sum[i]  = {1'b0, acc[i]} + {1'b0, num[i]};
            wrap[i] = (num[i] != '0) && (sum[i] >= {1'b0, den[i]});
        end
    end

    assign in_run    = (state == ST_RUN);
    assign run_stay  = in_run && (state_nxt == ST_RUN);
    assign cfg_ready = !pend_valid;
    assign cfg_take  = cfg_wr && !pend_valid;
    assign cfg_legal = (cfg_den != '0) && (cfg_num <= cfg_den) && (32'(cfg_ch) < CHANNELS);
    // Swapping ratios only at the channel's own wrap keeps the enable train glitch-free
    assign commit    = pend_valid &&
                       (!in_run || (num[pend_ch] == '0) || sync_req || wrap[pend_ch]);

    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_meta  <= 1'b0;
            lock_sync  <= 1'b0;
            state      <= ST_UNLOCKED;
            settle_cnt <= '0;
            locked     <= 1'b0;
            cfg_err    <= 1'b0;
            ce         <= '0;
            pend_valid <= 1'b0;
            pend_ch    <= '0;
            pend_num   <= '0;
            pend_den   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
                num[i] <= ACC_W'(DEF_NUM);
                den[i] <= ACC_W'(DEF_DEN);
            end
        end else begin
            lock_meta  <= pll_locked;
            lock_sync  <= lock_meta;
            state      <= state_nxt;
            settle_cnt <= (state == ST_SETTLE && state_nxt == ST_SETTLE) ? settle_cnt + 1'b1 : '0;
            locked     <= (state_nxt == ST_RUN);
            cfg_err    <= cfg_take && !cfg_legal;

            if (cfg_take && cfg_legal) begin
                pend_valid <= 1'b1;
                pend_ch    <= cfg_ch;
                pend_num   <= cfg_num;
                pend_den   <= cfg_den;
            end else if (commit) begin
                pend_valid <= 1'b0;
            end

            for (int i = 0; i < CHANNELS; i++) begin
                if (commit && pend_ch == CH_W'(i)) begin
                    num[i] <= pend_num;
                    den[i] <= pend_den;
                end
                ce[i] <= run_stay && !sync_req && wrap[i];
                if (run_stay && !sync_req && !(commit && pend_ch == CH_W'(i)))
                    acc[i] <= wrap[i] ? ACC_W'(sum[i] - {1'b0, den[i]}) : ACC_W'(sum[i]);
                else
                    acc[i] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_clk_ce_gen.sv
// tb/tb_clk_ce_gen.sv - randomized self-checking bench for clk_ce_gen against a closed-form reference model
module tb_clk_ce_gen;

    localparam int CHANNELS    = 2;
    localparam int ACC_W       = 16;
    localparam int LOCK_CYCLES = 8;
    localparam int DEF_NUM     = 1;
    localparam int DEF_DEN     = 2;
    localparam int CH_W        = 1;
    localparam int MAXC        = 8000;

    logic                refclk = 1'b0;
    logic                rst;
    logic                pll_locked;
    logic                cfg_wr;
    logic [CH_W-1:0]     cfg_ch;
    logic [ACC_W-1:0]    cfg_num;
    logic [ACC_W-1:0]    cfg_den;
    logic                cfg_ready;
    logic                cfg_err;
    logic                sync_req;
    logic [CHANNELS-1:0] ce;
    logic                locked;

    always #5 refclk = ~refclk;

    clk_ce_gen #(
        .CHANNELS(CHANNELS), .ACC_W(ACC_W), .LOCK_CYCLES(LOCK_CYCLES),
        .DEF_NUM(DEF_NUM), .DEF_DEN(DEF_DEN)
    ) dut (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked),
        .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_num(cfg_num), .cfg_den(cfg_den),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err), .sync_req(sync_req),
        .ce(ce), .locked(locked)
    );

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // Per-cycle input history: lock good (pll high, no reset) and reset
    bit good_h [MAXC];
    bit rst_h  [MAXC];

    // Model: each channel pulses when floor(n*num/den) steps, n = cycles since its last restart
    int m_num  [CHANNELS];
    int m_den  [CHANNELS];
    int m_base [CHANNELS];
    bit p_valid;
    int p_ch, p_num, p_den;

    logic [CHANNELS-1:0] exp_ce;
    logic                exp_locked, exp_ready, exp_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
        end
    endtask

    function automatic bit locked_at(input int c);
        if (c - LOCK_CYCLES - 3 < 0) return 1'b0;
        if (rst_h[c-1] || rst_h[c-2]) return 1'b0;
        for (int k = c - LOCK_CYCLES - 3; k <= c - 3; k++)
            if (!good_h[k]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit pulse(input int n, input int nm, input int dn);
        if (n < 1 || nm == 0 || dn == 0) return 1'b0;
        return ((longint'(n) * nm) / dn) != ((longint'(n - 1) * nm) / dn);
    endfunction

    task automatic model_update();
        bit                  lk_now, lk_next, cm, legal, was_pend;
        bit [CHANNELS-1:0]   w;
        if (cyc + 2 >= MAXC) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        good_h[cyc] = pll_locked && !rst;
        rst_h[cyc]  = rst;
        lk_now  = locked_at(cyc);
        lk_next = locked_at(cyc + 1);
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                m_num[i] = DEF_NUM; m_den[i] = DEF_DEN; m_base[i] = 0;
            end
            p_valid = 1'b0;
            exp_ce  = '0;
            exp_err = 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++)
                w[i] = lk_now && pulse(cyc + 1 - m_base[i], m_num[i], m_den[i]);
            for (int i = 0; i < CHANNELS; i++)
                exp_ce[i] = lk_now && lk_next && !sync_req && w[i];
            legal    = (int'(cfg_den) != 0) && (int'(cfg_num) <= int'(cfg_den));
            was_pend = p_valid;
            exp_err  = cfg_wr && !was_pend && !legal;
            cm = was_pend && (!lk_now || m_num[p_ch] == 0 || sync_req || w[p_ch]);
            if (cm) begin
                m_num[p_ch] = p_num; m_den[p_ch] = p_den; m_base[p_ch] = cyc + 1;
                p_valid = 1'b0;
            end
            if (cfg_wr && !was_pend && legal) begin
                p_valid = 1'b1; p_ch = int'(cfg_ch); p_num = int'(cfg_num); p_den = int'(cfg_den);
            end
            if ((lk_now && sync_req) || (lk_next && !lk_now))
                for (int i = 0; i < CHANNELS; i++) m_base[i] = cyc + 1;
        end
        exp_locked = lk_next;
        exp_ready  = !p_valid;
    endtask

    task automatic step();
        model_update();
        @(negedge refclk);
        cyc++;
        check("ce", ce, exp_ce);
        check("locked", locked, exp_locked);
        check("cfg_ready", cfg_ready, exp_ready);
        check("cfg_err", cfg_err, exp_err);
        cfg_wr   = 1'b0;
        sync_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic write(input int ch, input int n, input int d);
        cfg_wr  = 1'b1;
        cfg_ch  = CH_W'(ch);
        cfg_num = ACC_W'(n);
        cfg_den = ACC_W'(d);
        step();
    endtask

    initial begin
        int t_ref, first, f1, cnt, fb, fb2;
        rst = 1'b1; pll_locked = 1'b0; cfg_wr = 1'b0; cfg_ch = '0;
        cfg_num = '0; cfg_den = '0; sync_req = 1'b0;
        @(negedge refclk);
        idle(3);
        rst = 1'b0;
        idle(4);

        // Ratio written before lock commits straight away
        write(0, 3, 8);
        idle(3);

        pll_locked = 1'b1;
        t_ref = cyc;
        first = -1;
        for (int k = 0; k < 40 && first < 0; k++) begin
            step();
            if (locked) first = cyc;
        end
        check("lock_latency", first, t_ref + LOCK_CYCLES + 3);

        f1 = -1;
        for (int k = 0; k < 10 && f1 < 0; k++) begin
            step();
            if (ce[1]) f1 = cyc;
        end
        check("ce1_first", f1, first + 2);

        cnt = 0;
        for (int k = 0; k < 1000; k++) begin
            step();
            cnt += int'(ce[0]);
        end
        check("ce0_3of8_count", cnt, 375);

        // Runtime reconfig, illegal writes, ignored write while pending
        write(1, 1, 4);
        idle(20);
        write(0, 5, 4);
        idle(2);
        write(1, 1, 0);
        idle(2);
        write(0, 1, 8);
        write(0, 1, 3);
        idle(20);

        // Aligned restart of two channels
        write(0, 1, 3);
        idle(10);
        write(1, 1, 6);
        idle(15);
        sync_req = 1'b1;
        t_ref = cyc;
        step();
        fb = -1;
        for (int k = 0; k < 20 && fb < 0; k++) begin
            step();
            if (ce == 2'b11) fb = cyc;
        end
        check("sync_first_shared", fb, t_ref + 7);
        fb2 = -1;
        for (int k = 0; k < 20 && fb2 < 0; k++) begin
            step();
            if (ce == 2'b11) fb2 = cyc;
        end
        check("sync_second_shared", fb2, fb + 6);

        // Lock loss mid-run, then re-settle
        pll_locked = 1'b0;
        idle(3);
        check("loss_locked", locked, 1'b0);
        check("loss_ce", ce, '0);
        pll_locked = 1'b1;
        idle(20);

        // Reset during settle
        pll_locked = 1'b0;
        idle(5);
        pll_locked = 1'b1;
        idle(6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_ready", cfg_ready, 1'b1);
        idle(20);

        // Randomized traffic
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 99) < 10) begin
                cfg_wr  = 1'b1;
                cfg_ch  = CH_W'($urandom_range(0, 1));
                cfg_den = ACC_W'($urandom_range(0, 12));
                cfg_num = ACC_W'($urandom_range(0, 13));
            end
            if ($urandom_range(0, 49) == 0) sync_req = 1'b1;
            if (pll_locked && $urandom_range(0, 399) == 0) pll_locked = 1'b0;
            else if (!pll_locked && $urandom_range(0, 19) == 0) pll_locked = 1'b1;
            rst = ($urandom_range(0, 999) == 0);
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
